// File: rtl/stream_fifo_pkg.sv
// Shared helpers for stream_fifo_v2: count width, pointer wrap and stored word width.
// Macro STREAM_FIFO_PKT_MODE_EN widens each stored word by one TLAST bit.
package stream_fifo_pkg;

`ifdef STREAM_FIFO_PKT_MODE_EN
  localparam bit PKT_MODE = 1'b1;
`else
  localparam bit PKT_MODE = 1'b0;
`endif

  // Bits needed to hold the values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer increment that wraps at depth-1, so depth need not be a power of two.
  function automatic int ptr_next(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  // Stored word width: data plus TLAST when packet mode is built in.
  function automatic int word_width(input int width);
    return PKT_MODE ? width + 1 : width;
  endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// Simple dual-port memory for stream_fifo_v2: one write port, one registered read port.
// The read register doubles as the FIFO output stage, so it alone is reset.
module stream_fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  // NOTE: the array has no reset on purpose -- a reset would stop it mapping onto
  // block RAM, and stale words are never visible because the pointers are reset.
  // Non-blocking assignment keeps every register update ordered with the clock edge.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; holds its value when not enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/stream_fifo_v2.sv
// stream_fifo_v2: parametrised AXI-Stream FIFO with RAM storage and a
// first-word-fall-through output stage (the RAM read register).
// Macro STREAM_FIFO_PKT_MODE_EN adds TLAST, store-and-forward gating and
// oversize-packet cut-through release.
module stream_fifo_v2
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH         = 512,
  parameter int DEPTH         = 16384,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int CNT_W         = cnt_width(DEPTH)
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic [WIDTH-1:0] in0_V_V_TDATA,
  input  logic             in0_V_V_TVALID,
  output logic             in0_V_V_TREADY,
  output logic [WIDTH-1:0] out_V_V_TDATA,
  output logic             out_V_V_TVALID,
  input  logic             out_V_V_TREADY,
  output logic [CNT_W-1:0] count,
  output logic             almost_full,
  output logic             almost_empty
`ifdef STREAM_FIFO_PKT_MODE_EN
  ,
  input  logic             in0_V_V_TLAST,
  output logic             out_V_V_TLAST,
  output logic [CNT_W-1:0] pkt_count,
  output logic             oversize_err
`endif
);

  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WORD_W = word_width(WIDTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

  typedef logic [WORD_W-1:0] word_t;

  if (DEPTH < 2) begin : g_depth_check
    $error("stream_fifo_v2: DEPTH must be at least 2");
  end
  if (AEMPTY_THRESH >= AFULL_THRESH) begin : g_thresh_check
    $error("stream_fifo_v2: AEMPTY_THRESH must be below AFULL_THRESH");
  end

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic             stage_valid;
  logic             push, pop, ram_empty, rd_en;
  word_t            wr_word, rd_word;

  assign push = in0_V_V_TVALID & in0_V_V_TREADY;
  assign pop  = out_V_V_TVALID & out_V_V_TREADY;

  // The RAM can never hold DEPTH words: whenever it has data the output stage
  // is refilled first, so equal pointers always mean "RAM empty".
  assign ram_empty = (wr_ptr == rd_ptr);

  // Refill the stage when it is empty or draining this cycle.
  assign rd_en = !ram_empty && (!stage_valid || pop);

`ifdef STREAM_FIFO_PKT_MODE_EN
  assign wr_word = {in0_V_V_TLAST, in0_V_V_TDATA};
`else
  assign wr_word = in0_V_V_TDATA;
`endif
  assign out_V_V_TDATA = rd_word[WIDTH-1:0];

  stream_fifo_ram #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_word),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (rd_word)
  );

  // Occupancy after this edge: +1 push only, -1 pop only.
  // NOTE: every output of an always_comb gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (pop && !push) count_next = count - 1'b1;
  end

  // Pointers, occupancy, output stage valid, registered ready and flags.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      stage_valid    <= 1'b0;
      in0_V_V_TREADY <= 1'b0;
      almost_full    <= 1'b0;
      almost_empty   <= 1'b1;
    end else begin
      if (push)  wr_ptr <= AW'(ptr_next(int'(wr_ptr), DEPTH));
      if (rd_en) rd_ptr <= AW'(ptr_next(int'(rd_ptr), DEPTH));
      if (rd_en)    stage_valid <= 1'b1;
      else if (pop) stage_valid <= 1'b0;
      count          <= count_next;
      in0_V_V_TREADY <= (count_next < DEPTH_C);
      almost_full    <= (count_next >= AFULL_C);
      almost_empty   <= (count_next <= AEMPTY_C);
    end
  end

`ifdef STREAM_FIFO_PKT_MODE_EN
  logic             cut_through, deadlock, last_in, last_out;
  logic [CNT_W-1:0] pkt_count_next;

  assign out_V_V_TLAST  = rd_word[WIDTH];
  assign out_V_V_TVALID = stage_valid & ((pkt_count != '0) | cut_through);
  assign last_in        = push & in0_V_V_TLAST;
  assign last_out       = pop & out_V_V_TLAST;
  // Full of a single unterminated packet: nothing could ever leave.
  assign deadlock       = (count == DEPTH_C) && (pkt_count == '0);

  // Complete packets held: +1 on TLAST push, -1 on TLAST pop.
  always_comb begin
    pkt_count_next = pkt_count;
    if (last_in && !last_out)      pkt_count_next = pkt_count + 1'b1;
    else if (last_out && !last_in) pkt_count_next = pkt_count - 1'b1;
  end

  // Packet count, cut-through window and sticky oversize error.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      pkt_count    <= '0;
      cut_through  <= 1'b0;
      oversize_err <= 1'b0;
    end else begin
      pkt_count <= pkt_count_next;
      if (last_out)      cut_through <= 1'b0;
      else if (deadlock) cut_through <= 1'b1;
      if (deadlock) oversize_err <= 1'b1;
    end
  end
`else
  assign out_V_V_TVALID = stage_valid;
`endif

endmodule

// File: tb/tb_stream_fifo_v2.sv
// Directed testbench for stream_fifo_v2 (DEPTH=8, WIDTH=32, AFULL=6, AEMPTY=1).
// Packet-mode scenarios are built when STREAM_FIFO_PKT_MODE_EN is defined.
module tb_stream_fifo_v2;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  count;
  logic        af;
  logic        ae;
`ifdef STREAM_FIFO_PKT_MODE_EN
  logic        in_last;
  logic        out_last;
  logic [3:0]  pkt_count;
  logic        oversize_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  stream_fifo_v2 #(
    .WIDTH         (32),
    .DEPTH         (8),
    .AFULL_THRESH  (6),
    .AEMPTY_THRESH (1)
  ) dut (
    .ap_clk         (ap_clk),
    .ap_rst         (ap_rst),
    .in0_V_V_TDATA  (in_data),
    .in0_V_V_TVALID (in_valid),
    .in0_V_V_TREADY (in_ready),
    .out_V_V_TDATA  (out_data),
    .out_V_V_TVALID (out_valid),
    .out_V_V_TREADY (out_ready),
    .count          (count),
    .almost_full    (af),
    .almost_empty   (ae)
`ifdef STREAM_FIFO_PKT_MODE_EN
    ,
    .in0_V_V_TLAST  (in_last),
    .out_V_V_TLAST  (out_last),
    .pkt_count      (pkt_count),
    .oversize_err   (oversize_err)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (count !== 4'd0)    begin n_bad++; $display("FAIL rst_count: got %0d expected 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL rst_out_data: got %h expected 0", out_data); end
    n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    n_cmp++; if (af !== 1'b0)        begin n_bad++; $display("FAIL rst_almost_full: got %b expected 0", af); end
    n_cmp++; if (ae !== 1'b1)        begin n_bad++; $display("FAIL rst_almost_empty: got %b expected 1", ae); end
    ap_rst = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL rel_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hA5A5_0001;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (count !== 4'd1)     begin n_bad++; $display("FAIL single_count1: got %0d expected 1", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %b expected 0", out_valid); end
    n_cmp++; if (ae !== 1'b1)        begin n_bad++; $display("FAIL single_ae1: got %b expected 1", ae); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    n_cmp++; if (out_data !== 32'hA5A5_0001) begin n_bad++; $display("FAIL single_data: got %h expected a5a50001", out_data); end
    tick();
    n_cmp++; if (count !== 4'd0)     begin n_bad++; $display("FAIL single_count0: got %0d expected 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid0: got %b expected 0", out_valid); end
    n_cmp++; if (ae !== 1'b1)        begin n_bad++; $display("FAIL single_ae0: got %b expected 1", ae); end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 32'h1000_0000 + 32'(i);
      tick();
      n_cmp++; if (int'(count) !== i + 1) begin n_bad++; $display("FAIL full_count[%0d]: got %0d expected %0d", i, count, i + 1); end
      n_cmp++; if (af !== (i + 1 >= 6)) begin n_bad++; $display("FAIL full_af[%0d]: got %b expected %b", i, af, (i + 1 >= 6)); end
      n_cmp++; if (ae !== (i + 1 <= 1)) begin n_bad++; $display("FAIL full_ae[%0d]: got %b expected %b", i, ae, (i + 1 <= 1)); end
      n_cmp++; if (in_ready !== (i + 1 < 8)) begin n_bad++; $display("FAIL full_ready[%0d]: got %b expected %b", i, in_ready, (i + 1 < 8)); end
    end
    // Source keeps offering a word while one pop happens: no push may sneak in.
    in_valid = 1'b1; in_data = 32'hBAD0_0008; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (count !== 4'd7)     begin n_bad++; $display("FAIL full_pop_count: got %0d expected 7", count); end
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL full_pop_ready: got %b expected 1", in_ready); end
    for (int k = 1; k < 8; k++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h1000_0000 + 32'(k)) begin
        n_bad++; $display("FAIL full_drain[%0d]: got v=%b %h expected v=1 %h", k, out_valid, out_data, 32'h1000_0000 + 32'(k));
      end
      tick();
    end
    n_cmp++; if (count !== 4'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL full_empty: got count=%0d v=%b expected 0 0", count, out_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] q[$];
    logic [31:0] exp;
    int n_push = 0;
    int n_pop = 0;
    bit done = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc >= 100 && n_pop >= 88) begin done = 1'b1; break; end
      out_ready = ($urandom_range(7, 0) != 0);
      in_valid = 1'b1; in_data = 32'h5000_0000 + 32'(n_push);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL stream_spurious: got valid with data %h expected no word", out_data);
        end else begin
          exp = q.pop_front();
          n_cmp++; if (out_data !== exp) begin n_bad++; $display("FAIL stream_data: got %h expected %h", out_data, exp); end
        end
        n_pop++;
      end
      if (in_ready) begin q.push_back(in_data); n_push++; end
      tick();
      n_cmp++; if (int'(count) !== q.size()) begin n_bad++; $display("FAIL stream_count: got %0d expected %0d", count, q.size()); end
      n_cmp++; if (count > 4'd8) begin n_bad++; $display("FAIL stream_overflow: got %0d expected <=8", count); end
    end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL stream_budget: got %0d pops expected >=88", n_pop); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      if (out_valid) begin
        exp = q.pop_front();
        n_cmp++; if (out_data !== exp) begin n_bad++; $display("FAIL stream_drain: got %h expected %h", out_data, exp); end
      end
      tick();
    end
    n_cmp++; if (q.size() != 0 || count !== 4'd0) begin n_bad++; $display("FAIL stream_end: got left=%0d count=%0d expected 0 0", q.size(), count); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'hE000_0000 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hE000_0000) begin
        n_bad++; $display("FAIL hold[%0d]: got v=%b %h expected v=1 e0000000", i, out_valid, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hE000_0000 + 32'(i)) begin
        n_bad++; $display("FAIL hold_drain[%0d]: got v=%b %h expected v=1 %h", i, out_valid, out_data, 32'hE000_0000 + 32'(i));
      end
      tick();
    end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL hold_end: got %0d expected 0", count); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'hF000_0000 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (count !== 4'd5 || af !== 1'b0 || ae !== 1'b0) begin
      n_bad++; $display("FAIL mid_pre: got count=%0d af=%b ae=%b expected 5 0 0", count, af, ae);
    end
    ap_rst = 1'b1;
    #1;
    n_cmp++; if (count !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL mid_async: got count=%0d v=%b rdy=%b expected 0 0 0", count, out_valid, in_ready);
    end
    tick();
    ap_rst = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b expected 1", in_ready); end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h6000_0001;
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h6000_0001) begin
      n_bad++; $display("FAIL mid_first: got v=%b %h expected v=1 60000001", out_valid, out_data);
    end
    tick();
    n_cmp++; if (count !== 4'd0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_end: got count=%0d v=%b expected 0 0", count, out_valid);
    end
  endtask

`ifdef STREAM_FIFO_PKT_MODE_EN
  task automatic test_pkt_small();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h7000_0000 + 32'(i); in_last = (i == 2);
      tick();
      n_cmp++; if (out_valid !== (i == 2)) begin n_bad++; $display("FAIL pkt_gate[%0d]: got %b expected %b", i, out_valid, (i == 2)); end
    end
    in_valid = 1'b0; in_last = 1'b1;
    n_cmp++; if (pkt_count !== 4'd1) begin n_bad++; $display("FAIL pkt_cnt1: got %0d expected 1", pkt_count); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h7000_0000 + 32'(i) || out_last !== (i == 2)) begin
        n_bad++; $display("FAIL pkt_word[%0d]: got v=%b %h l=%b expected v=1 %h l=%b", i, out_valid, out_data, out_last, 32'h7000_0000 + 32'(i), (i == 2));
      end
      n_cmp++; if (pkt_count !== 4'd1) begin n_bad++; $display("FAIL pkt_cnt_hold[%0d]: got %0d expected 1", i, pkt_count); end
      tick();
    end
    n_cmp++; if (pkt_count !== 4'd0 || out_valid !== 1'b0 || oversize_err !== 1'b0) begin
      n_bad++; $display("FAIL pkt_end: got pc=%0d v=%b err=%b expected 0 0 0", pkt_count, out_valid, oversize_err);
    end
  endtask

  task automatic test_pkt_oversize();
    int sent = 0;
    int rcvd = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && rcvd < 10; cyc++) begin
      in_valid = (sent < 10); in_data = 32'h8000_0000 + 32'(sent); in_last = (sent == 9);
      if (out_valid) begin
        n_cmp++; if (out_data !== 32'h8000_0000 + 32'(rcvd) || out_last !== (rcvd == 9)) begin
          n_bad++; $display("FAIL ovs_word[%0d]: got %h l=%b expected %h l=%b", rcvd, out_data, out_last, 32'h8000_0000 + 32'(rcvd), (rcvd == 9));
        end
        if (rcvd < 9) begin
          n_cmp++; if (oversize_err !== 1'b1) begin n_bad++; $display("FAIL ovs_err_flow[%0d]: got %b expected 1", rcvd, oversize_err); end
        end
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0; in_last = 1'b1;
    n_cmp++; if (rcvd !== 10) begin n_bad++; $display("FAIL ovs_rcvd: got %0d expected 10", rcvd); end
    n_cmp++; if (oversize_err !== 1'b1 || pkt_count !== 4'd0 || count !== 4'd0) begin
      n_bad++; $display("FAIL ovs_end: got err=%b pc=%0d count=%0d expected 1 0 0", oversize_err, pkt_count, count);
    end
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    tick();
    n_cmp++; if (oversize_err !== 1'b0) begin n_bad++; $display("FAIL ovs_clear: got %b expected 0", oversize_err); end
  endtask
`endif

  initial begin
`ifdef STREAM_FIFO_PKT_MODE_EN
    // Word-level scenarios run as one-word packets.
    in_last = 1'b1;
`endif
    test_reset();
    test_single();
    test_full();
    test_stream();
    test_backpressure();
    test_reset_mid();
`ifdef STREAM_FIFO_PKT_MODE_EN
    test_pkt_small();
    test_pkt_oversize();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_fifo_v2.md
Name: stream_fifo_v2

Overview:
- Parametrised AXI-Stream FIFO.
- Successor to the fixed-configuration Q_srl streaming FIFO wrappers: width, depth and watermark thresholds are parameters.
- Memory is RAM-inferred (simple dual-port, registered read) with a first-word-fall-through output stage.
- Provides an occupancy count and almost-full/almost-empty flags. Optional packet (store-and-forward) mode.
- Sits between dataflow layers for rate decoupling and deadlock-free buffering.

Parameters:
- WIDTH, 512, TDATA width in bits (≥1).
- DEPTH, 16384, total word capacity (≥2; need not be a power of two).
- AFULL_THRESH, DEPTH-2, almost_full asserted when count ≥ this value.
- AEMPTY_THRESH, 2, almost_empty asserted when count ≤ this value.
- CNT_W, $clog2(DEPTH+1), count width (derived; do not override).

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst  in  1  asynchronous reset, active-high.
- in0_V_V_TDATA  in  WIDTH  input data.
- in0_V_V_TVALID  in  1  input valid.
- in0_V_V_TREADY  out  1  input ready.
- out_V_V_TDATA  out  WIDTH  output data.
- out_V_V_TVALID  out  1  output valid.
- out_V_V_TREADY  in  1  output ready.
- count  out  CNT_W  words held (RAM plus output stage).
- almost_full  out  1  count ≥ AFULL_THRESH.
- almost_empty  out  1  count ≤ AEMPTY_THRESH.

Behaviour:
- Reset: async assert, synchronous release. While asserted:
  - count, wr_ptr, rd_ptr = 0; out TVALID = 0; out TDATA = 0.
  - in0 TREADY = 0; almost_full = 0; almost_empty = 1.
  - After the first clock edge with reset low, in0 TREADY = 1.
  - Reset mid-transfer discards all contents; no partial word survives.
- Push = in0 TVALID & in0 TREADY. Pop = out TVALID & out TREADY.
- in0 TREADY = registered (count < DEPTH). No combinational path from out TREADY to in0 TREADY.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds DEPTH and never underflows.
- Pointers wrap from DEPTH-1 to 0 explicitly. No power-of-two assumption.
- Latency: a word pushed into an empty FIFO at edge N is presented with out TVALID = 1 after edge N+1 (one cycle).
- Throughput: one word per cycle sustained in steady state, including with the FIFO full and out TREADY held high.
- Output stage: out TDATA and TVALID are held stable while TVALID = 1 and TREADY = 0 (AXI rule). The stage refills in the same cycle it drains when the RAM is non-empty (prefetch / skid entry).
- Full: count = DEPTH forces in0 TREADY = 0. A pop in that cycle does not enable a same-cycle push; TREADY rises the following cycle.
- Empty: out TVALID = 0. A push and out TREADY in the same cycle do not produce a pop.
- Flags are registered and derived from next-count, so they are coincident with count.
- Elaboration-time checks: error if DEPTH < 2 or AEMPTY_THRESH ≥ AFULL_THRESH.

Optional Feature:
- Macro: STREAM_FIFO_PKT_MODE_EN.
- Defined:
  - Adds ports in0_V_V_TLAST (in, 1), out_V_V_TLAST (out, 1), pkt_count (out, CNT_W) and oversize_err (out, 1, sticky).
  - Stores TLAST alongside the data.
  - pkt_count increments on a push with TLAST and decrements on a pop with TLAST; both in one cycle leave it unchanged.
  - out TVALID is asserted only while pkt_count > 0 (store-and-forward).
  - Deadlock release: if count = DEPTH and pkt_count = 0, gating is dropped (cut-through) until the next TLAST pop, and oversize_err is set. oversize_err is cleared only by reset.
- Undefined: the TLAST ports are absent and behaviour is pure word FIFO.

Decomposition:
- Package stream_fifo_pkg:
  - cnt_width(depth) function.
  - Pointer-increment-with-wrap function.
  - Packet-mode word typedef helper.
- Sub-module stream_fifo_ram:
  - Simple dual-port memory, WIDTH(+1) × DEPTH, registered read port.
  - Carries the RAM-style synthesis attribute.
- Top level: pointers, count, output stage, flags, packet logic.

Test Plan (DEPTH=8, WIDTH=32, AFULL_THRESH=6, AEMPTY_THRESH=1 unless stated):
- Reset then push 0xA5A5_0001 with out TREADY = 1 -> out TVALID one cycle later, data 0xA5A5_0001, count 1→0, almost_empty stays 1.
- Push 8 words with out TREADY = 0:
  - count reaches 8 and in0 TREADY = 0 the cycle after the 8th push.
  - almost_full = 1 from count = 6.
  - Then one pop -> TREADY = 1 the next cycle, with no same-cycle push.
- Continuous push and pop for 100 cycles with random out TREADY -> data in order, count never > 8, and pointer wrap exercised at least 10 times.
- Back-pressure hold: out TREADY = 0 for 5 cycles with TVALID = 1 -> out TDATA unchanged on every cycle.
- Assert ap_rst for 1 cycle with count = 5 -> count = 0, out TVALID = 0 immediately; the next pushed word is the first word seen at the output.
- STREAM_FIFO_PKT_MODE_EN:
  - 3-word packet with TLAST on the 3rd -> out TVALID stays 0 until after the 3rd push, then 3 pops and pkt_count goes 1→0.
  - A 10-word packet -> oversize_err = 1, output flows cut-through, and all 10 words are received in order.
